// File: rtl/fsm_div_pkg.sv
// Shared definitions for the two-division sequencer: state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_div_pkg;

   // Parameter defaults
   localparam int W_DEFAULT       = 4;
   localparam int TMO_CYC_DEFAULT = 64;

   // State encoding
   localparam logic [3:0] IN_A      = 4'd0;
   localparam logic [3:0] IN_B      = 4'd1;
   localparam logic [3:0] IN_C      = 4'd2;
   localparam logic [3:0] IN_D      = 4'd3;
   localparam logic [3:0] DIV1_REQ  = 4'd4;
   localparam logic [3:0] DIV1_WAIT = 4'd5;
   localparam logic [3:0] DIV2_REQ  = 4'd6;
   localparam logic [3:0] DIV2_WAIT = 4'd7;
   localparam logic [3:0] SHOW      = 4'd8;

endpackage

// File: rtl/fsm_div_wdog.sv
// Divider watchdog: counts cycles since div_start and flags expiry at TMO_CYC (FSM_DIV_TIMEOUT_EN only).
// Latency: expired is combinational from the count, valid in the last WAIT cycle before the limit.
// Backpressure: none; clr restarts the count, en advances it.
`ifdef FSM_DIV_TIMEOUT_EN
module fsm_div_wdog #(
   parameter int TMO_CYC = fsm_div_pkg::TMO_CYC_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] cnt;

   // The request cycle itself counts as the first elapsed cycle, so clr loads 1;
   // expiry in the cycle holding TMO_CYC-1 lands SHOW exactly TMO_CYC cycles after div_start.
   assign expired = en && (cnt >= CW'(TMO_CYC - 1));

   // Elapsed-cycle counter, restarted on every division request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= CW'(1);
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule
`endif

// File: rtl/fsm_div_seq.sv
// Operand-entry sequencer: res = a/b + c/d (mod 2^W) using one shared divider twice.
// Latency: 4 presses + 2 cycles per division + divider latency; watchdog via FSM_DIV_TIMEOUT_EN.
// Backpressure: presses ignored while dividing; waits on div_done (or watchdog) in WAIT states.
module fsm_div_seq
   import fsm_div_pkg::*;
#(
   parameter int W       = W_DEFAULT,
   parameter int TMO_CYC = TMO_CYC_DEFAULT
) (
   input  logic         clk,
   input  logic         btn_reset_in,
   input  logic         btn_c_pulse,
   input  logic [W-1:0] sw,
   output logic         div_start,
   output logic [W-1:0] div_dividend,
   output logic [W-1:0] div_divisor,
   input  logic         div_done,
   input  logic [W-1:0] div_quot,
   input  logic         div_err,
   output logic [W-1:0] op_disp,
   output logic [W-1:0] res,
   output logic         err,
   output logic         valid_out_LED
);

   logic [3:0]   state;
   logic [W-1:0] op_a, op_b, op_c, op_d;
   logic [W-1:0] q1;
   logic         tmo;

`ifdef FSM_DIV_TIMEOUT_EN
   fsm_div_wdog #(
      .TMO_CYC (TMO_CYC)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (btn_reset_in),
      .clr     ((state == DIV1_REQ) || (state == DIV2_REQ)),
      .en      ((state == DIV1_WAIT) || (state == DIV2_WAIT)),
      .expired (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   // Divider request: start is a one-cycle strobe from the REQ state; operands stay on the bus through WAIT
   always_comb begin
      div_start    = 1'b0;
      div_dividend = '0;
      div_divisor  = '0;
      case (state)
         DIV1_REQ, DIV1_WAIT: begin
            div_start    = (state == DIV1_REQ);
            div_dividend = op_a;
            div_divisor  = op_b;
         end
         DIV2_REQ, DIV2_WAIT: begin
            div_start    = (state == DIV2_REQ);
            div_dividend = op_c;
            div_divisor  = op_d;
         end
         default: ;
      endcase
   end

   // Sequencer: operand entry, two divisions, result display; reset aborts anything in flight
   always_ff @(posedge clk or negedge btn_reset_in) begin
      if (!btn_reset_in) begin
         state         <= IN_A;
         op_a          <= '0;
         op_b          <= '0;
         op_c          <= '0;
         op_d          <= '0;
         q1            <= '0;
         op_disp       <= '0;
         res           <= '0;
         err           <= 1'b0;
         valid_out_LED <= 1'b0;
      end else begin
         case (state)
            IN_A: if (btn_c_pulse) begin
               op_a    <= sw;
               op_disp <= sw;
               state   <= IN_B;
            end
            IN_B: if (btn_c_pulse) begin
               op_b    <= sw;
               op_disp <= sw;
               state   <= IN_C;
            end
            IN_C: if (btn_c_pulse) begin
               op_c    <= sw;
               op_disp <= sw;
               state   <= IN_D;
            end
            IN_D: if (btn_c_pulse) begin
               op_d    <= sw;
               op_disp <= sw;
               state   <= DIV1_REQ;
            end
            DIV1_REQ: state <= DIV1_WAIT;
            DIV1_WAIT: begin
               if (div_done) begin
                  if (div_err) begin
                     // Divide-by-zero: second division is skipped
                     res           <= '0;
                     err           <= 1'b1;
                     valid_out_LED <= 1'b1;
                     state         <= SHOW;
                  end else begin
                     q1    <= div_quot;
                     state <= DIV2_REQ;
                  end
               end else if (tmo) begin
                  res           <= '0;
                  err           <= 1'b1;
                  valid_out_LED <= 1'b1;
                  state         <= SHOW;
               end
            end
            DIV2_REQ: state <= DIV2_WAIT;
            DIV2_WAIT: begin
               if (div_done) begin
                  res           <= div_err ? '0 : W'(q1 + div_quot);
                  err           <= div_err;
                  valid_out_LED <= 1'b1;
                  state         <= SHOW;
               end else if (tmo) begin
                  res           <= '0;
                  err           <= 1'b1;
                  valid_out_LED <= 1'b1;
                  state         <= SHOW;
               end
            end
            SHOW: if (btn_c_pulse) begin
               // Acknowledge press only clears the display; it is not an operand
               res           <= '0;
               err           <= 1'b0;
               valid_out_LED <= 1'b0;
               op_disp       <= '0;
               state         <= IN_A;
            end
            default: state <= IN_A;
         endcase
      end
   end

endmodule
